// File: rtl/hms_countdown.sv
// hms_countdown: settable HH:MM:SS countdown, one decrement every CLK_FREQ clocks; `define AUTO_RELOAD_EN to restart from the start value at zero.
// All outputs registered (one-cycle latency from inputs); no backpressure, pulse inputs act on the cycle they arrive.
module hms_countdown #(
  parameter int CLK_FREQ  = 50000000,
  parameter int MAX_HOURS = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       plus,
  input  logic       minus,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int            PW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [4:0]    HOUR_MAX   = 5'(MAX_HOURS);
  localparam logic [5:0]    MS_MAX     = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2,
    SET     = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_hours, w_hours_nxt;
  logic [5:0]    r_mins, w_mins_nxt;
  logic [5:0]    r_secs, w_secs_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_done, w_done_nxt;

  logic          w_tick;
  logic          w_nonzero;
  logic          w_step_up;
  logic          w_step_dn;
  logic [4:0]    w_dec_hours;
  logic [5:0]    w_dec_mins;
  logic [5:0]    w_dec_secs;
  logic          w_dec_zero;

  // plus and minus together cancel out
  assign w_step_up = plus & ~minus;
  assign w_step_dn = minus & ~plus;
  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_nonzero = (r_hours != 5'd0) || (r_mins != 6'd0) || (r_secs != 6'd0);

  function automatic logic [5:0] f_step_ms(input logic [5:0] v, input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up)      r = (v == MS_MAX) ? 6'd0 : v + 6'd1;
    else if (dn) r = (v == 6'd0) ? MS_MAX : v - 6'd1;
    return r;
  endfunction

  function automatic logic [4:0] f_step_h(input logic [4:0] v, input logic up, input logic dn);
    logic [4:0] r;
    r = v;
    if (up)      r = (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
    else if (dn) r = (v == 5'd0) ? HOUR_MAX : v - 5'd1;
    return r;
  endfunction

  // One-second borrow chain: secs first, then mins, then hours
  always_comb begin
    w_dec_hours = r_hours;
    w_dec_mins  = r_mins;
    w_dec_secs  = r_secs;
    if (r_secs != 6'd0) begin
      w_dec_secs = r_secs - 6'd1;
    end else if (r_mins != 6'd0) begin
      w_dec_mins = r_mins - 6'd1;
      w_dec_secs = MS_MAX;
    end else if (r_hours != 5'd0) begin
      w_dec_hours = r_hours - 5'd1;
      w_dec_mins  = MS_MAX;
      w_dec_secs  = MS_MAX;
    end
  end

  assign w_dec_zero = (w_dec_hours == 5'd0) && (w_dec_mins == 6'd0) && (w_dec_secs == 6'd0);

`ifdef AUTO_RELOAD_EN
  logic [4:0] r_rl_hours;
  logic [5:0] r_rl_mins;
  logic [5:0] r_rl_secs;
  logic       w_capture;

  assign w_capture = (r_state == IDLE) && (w_state_nxt == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rl_hours <= 5'd0;
      r_rl_mins  <= 6'd0;
      r_rl_secs  <= 6'd0;
    end else if (w_capture) begin
      r_rl_hours <= r_hours;
      r_rl_mins  <= r_mins;
      r_rl_secs  <= r_secs;
    end
  end
`endif

  // Next-state and datapath; mode != 00 overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    w_hours_nxt = r_hours;
    w_mins_nxt  = r_mins;
    w_secs_nxt  = r_secs;
    w_presc_nxt = r_presc;
    w_done_nxt  = 1'b0;

    if (mode != 2'b00) begin
      w_state_nxt = SET;
      if (r_state == SET) begin
        case (mode)
          2'b01:   w_secs_nxt  = f_step_ms(r_secs, w_step_up, w_step_dn);
          2'b10:   w_mins_nxt  = f_step_ms(r_mins, w_step_up, w_step_dn);
          default: w_hours_nxt = f_step_h(r_hours, w_step_up, w_step_dn);
        endcase
      end
    end else begin
      case (r_state)
        SET: w_state_nxt = IDLE;

        IDLE: begin
          if (start && w_nonzero) begin
            w_state_nxt = RUN;
            w_presc_nxt = '0;
          end
        end

        RUN: begin
          if (w_tick) begin
            w_presc_nxt = '0;
            w_hours_nxt = w_dec_hours;
            w_mins_nxt  = w_dec_mins;
            w_secs_nxt  = w_dec_secs;
            if (w_dec_zero) begin
              w_done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
              w_hours_nxt = r_rl_hours;
              w_mins_nxt  = r_rl_mins;
              w_secs_nxt  = r_rl_secs;
              w_state_nxt = start ? IDLE : RUN;
`else
              w_state_nxt = EXPIRED;
`endif
            end else if (start) begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
            if (start) w_state_nxt = IDLE;
          end
        end

        EXPIRED: begin
          if (start) w_state_nxt = IDLE;
        end

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hours <= 5'd0;
      r_mins  <= 6'd0;
      r_secs  <= 6'd0;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hours <= w_hours_nxt;
      r_mins  <= w_mins_nxt;
      r_secs  <= w_secs_nxt;
      r_presc <= w_presc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign hours   = r_hours;
  assign mins    = r_mins;
  assign secs    = r_secs;
  assign running = (r_state == RUN);
  assign expired = (r_state == EXPIRED);
  assign done    = r_done;

endmodule

// File: tb/tb_hms_countdown.sv
// Bench for hms_countdown (CLK_FREQ=4): directed stimulus queues expected outputs per cycle; a negedge monitor compares them.
module tb_hms_countdown;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic       plus;
  logic       minus;
  logic [4:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       running;
  logic       expired;
  logic       done;

  hms_countdown #(.CLK_FREQ(4), .MAX_HOURS(23)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .plus    (plus),
    .minus   (minus),
    .hours   (hours),
    .mins    (mins),
    .secs    (secs),
    .running (running),
    .expired (expired),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       run;
    logic       exp;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected output state d posedges from now
  task automatic expect_v(input string nm, input int d, input int h, input int m, input int s,
                          input int run, input int ex, input int dn);
    exp_t e;
    e.at   = cyc + d;
    e.name = nm;
    e.h    = 5'(h);
    e.m    = 6'(m);
    e.s    = 6'(s);
    e.run  = 1'(run);
    e.exp  = 1'(ex);
    e.dn   = 1'(dn);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        n_vec++;
        if (hours !== sb[i].h || mins !== sb[i].m || secs !== sb[i].s ||
            running !== sb[i].run || expired !== sb[i].exp || done !== sb[i].dn) begin
          n_bad++;
          $display("FAIL %s @cycle %0d: got %0d:%0d:%0d run=%b exp=%b done=%b, want %0d:%0d:%0d run=%b exp=%b done=%b",
                   sb[i].name, cyc, hours, mins, secs, running, expired, done,
                   sb[i].h, sb[i].m, sb[i].s, sb[i].run, sb[i].exp, sb[i].dn);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: expected at cycle %0d was never sampled", sb[i].name, sb[i].at);
        sb.delete(i);
      end
    end
  end

  task automatic cyc1();
    @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    cyc1();
  endtask

  // One plus/minus pulse while in SET, then one idle cycle
  task automatic edit(input logic p, input logic mi, input string nm, input int h, input int m, input int s);
    plus  = p;
    minus = mi;
    expect_v(nm, 1, h, m, s, 0, 0, 0);
    cyc1();
    plus  = 1'b0;
    minus = 1'b0;
    cyc1();
  endtask

  task automatic pulse_reset(input string nm);
    reset = 1'b1;
    expect_v(nm, 1, 0, 0, 0, 0, 0, 0);
    cyc1();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    plus  = 1'b0;
    minus = 1'b0;
    repeat (2) cyc1();

    // Reset state and field editing
    expect_v("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc1();
    reset = 1'b0;
    expect_v("reset_release", 1, 0, 0, 0, 0, 0, 0);
    cyc1();
    set_mode(2'b01);
    edit(1, 0, "sec_plus1", 0, 0, 1);
    edit(1, 0, "sec_plus2", 0, 0, 2);
    edit(1, 0, "sec_plus3", 0, 0, 3);
    set_mode(2'b10);
    edit(0, 1, "min_wrap_down", 0, 59, 3);
    mode = 2'b00;
    expect_v("idle_005903", 1, 0, 59, 3, 0, 0, 0);
    cyc1();

    // Bring value to 00:00:02
    set_mode(2'b10);
    edit(1, 0, "min_wrap_up", 0, 0, 3);
    set_mode(2'b01);
    edit(0, 1, "sec_minus", 0, 0, 2);
    set_mode(2'b00);

`ifdef AUTO_RELOAD_EN
    start = 1'b1;
    expect_v("rl_start", 1, 0, 0, 2, 1, 0, 0);
    expect_v("rl_tick1", 5, 0, 0, 1, 1, 0, 0);
    expect_v("rl_reload1", 9, 0, 0, 2, 1, 0, 1);
    expect_v("rl_done_off1", 10, 0, 0, 2, 1, 0, 0);
    expect_v("rl_tick2", 13, 0, 0, 1, 1, 0, 0);
    expect_v("rl_reload2", 17, 0, 0, 2, 1, 0, 1);
    expect_v("rl_done_off2", 18, 0, 0, 2, 1, 0, 0);
    cyc1();
    start = 1'b0;
    repeat (17) cyc1();
    start = 1'b1;
    expect_v("rl_pause", 1, 0, 0, 2, 0, 0, 0);
    cyc1();
    start = 1'b0;
    cyc1();
`else
    // Run down to expiry
    start = 1'b1;
    expect_v("run_start", 1, 0, 0, 2, 1, 0, 0);
    expect_v("pre_tick1", 4, 0, 0, 2, 1, 0, 0);
    expect_v("tick1", 5, 0, 0, 1, 1, 0, 0);
    expect_v("pre_tick2", 8, 0, 0, 1, 1, 0, 0);
    expect_v("expire_done", 9, 0, 0, 0, 0, 1, 1);
    expect_v("done_one_cycle", 10, 0, 0, 0, 0, 1, 0);
    expect_v("expired_hold", 29, 0, 0, 0, 0, 1, 0);
    cyc1();
    start = 1'b0;
    repeat (28) cyc1();
    start = 1'b1;
    expect_v("ack", 1, 0, 0, 0, 0, 0, 0);
    cyc1();
    start = 1'b0;
    cyc1();
    start = 1'b1;
    expect_v("zero_start_ignored", 1, 0, 0, 0, 0, 0, 0);
    expect_v("zero_start_still_idle", 3, 0, 0, 0, 0, 0, 0);
    cyc1();
    start = 1'b0;
    repeat (2) cyc1();
`endif

    // 01:00:00 borrow across all fields, pause coinciding with the tick
    pulse_reset("reset_c");
    set_mode(2'b11);
    edit(1, 0, "hour_plus", 1, 0, 0);
    set_mode(2'b00);
    start = 1'b1;
    expect_v("h_start", 1, 1, 0, 0, 1, 0, 0);
    expect_v("h_pre_tick", 4, 1, 0, 0, 1, 0, 0);
    expect_v("h_borrow_pause", 5, 0, 59, 59, 0, 0, 0);
    expect_v("h_paused_hold", 7, 0, 59, 59, 0, 0, 0);
    cyc1();
    start = 1'b0;
    repeat (3) cyc1();
    start = 1'b1;
    cyc1();
    start = 1'b0;
    repeat (3) cyc1();

    // Edit wraps at field limits, no carry between fields
    pulse_reset("reset_d");
    set_mode(2'b11);
    edit(0, 1, "hour_wrap_down", 23, 0, 0);
    edit(1, 1, "plus_minus_cancel", 23, 0, 0);
    edit(1, 0, "hour_wrap_up", 0, 0, 0);
    set_mode(2'b10);
    edit(0, 1, "min_no_borrow", 0, 59, 0);
    set_mode(2'b01);
    edit(0, 1, "sec_no_borrow", 0, 59, 59);
    set_mode(2'b10);
    edit(1, 0, "min_no_carry", 0, 0, 59);
    set_mode(2'b01);
    edit(1, 0, "sec_no_carry", 0, 0, 0);
    for (int i = 1; i <= 5; i++) edit(1, 0, "sec_up", 0, 0, i);
    set_mode(2'b00);

    // Pause between ticks, resume, SET mid-count, reset while running
    start = 1'b1;
    expect_v("p_start", 1, 0, 0, 5, 1, 0, 0);
    expect_v("p_pre_tick", 4, 0, 0, 5, 1, 0, 0);
    expect_v("p_tick", 5, 0, 0, 4, 1, 0, 0);
    cyc1();
    start = 1'b0;
    repeat (5) cyc1();
    start = 1'b1;
    expect_v("p_paused", 1, 0, 0, 4, 0, 0, 0);
    expect_v("p_frozen_12", 13, 0, 0, 4, 0, 0, 0);
    cyc1();
    start = 1'b0;
    repeat (12) cyc1();
    start = 1'b1;
    expect_v("r_resume", 1, 0, 0, 4, 1, 0, 0);
    expect_v("r_pre_tick", 4, 0, 0, 4, 1, 0, 0);
    expect_v("r_tick", 5, 0, 0, 3, 1, 0, 0);
    cyc1();
    start = 1'b0;
    repeat (5) cyc1();
    mode = 2'b01;
    expect_v("set_freeze", 1, 0, 0, 3, 0, 0, 0);
    cyc1();
    plus = 1'b1;
    expect_v("set_plus", 1, 0, 0, 4, 0, 0, 0);
    expect_v("set_frozen", 6, 0, 0, 4, 0, 0, 0);
    cyc1();
    plus = 1'b0;
    repeat (5) cyc1();
    mode = 2'b00;
    expect_v("set_exit", 1, 0, 0, 4, 0, 0, 0);
    cyc1();
    start = 1'b1;
    expect_v("run_again", 1, 0, 0, 4, 1, 0, 0);
    cyc1();
    start = 1'b0;
    cyc1();
    reset = 1'b1;
    start = 1'b1;
    expect_v("reset_in_run", 1, 0, 0, 0, 0, 0, 0);
    cyc1();
    reset = 1'b0;
    start = 1'b0;
    expect_v("after_reset", 1, 0, 0, 0, 0, 0, 0);
    cyc1();

    for (int k = 0; k < 50 && sb.size() != 0; k++) cyc1();
    if (sb.size() != 0) begin
      n_vec += sb.size();
      n_bad += sb.size();
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
